// File: rtl/divisor_multiple_gen.sv
// Streams every multiple of the selected divisor in ascending order over a valid/ready port.
// Optional build macro DIVMULT_SKIP_ZERO_EN starts the stream at d instead of 0.
module divisor_multiple_gen #(
  parameter int WIDTH = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [2:0]       sel,
  output logic             busy,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_last,
  output logic             done
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_EMIT = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam int DW = 4;
  // Two spare bits so value + d can never overflow the compare.
  localparam int SW = WIDTH + 2;
  localparam logic [SW-1:0] MAXV = {2'b00, {WIDTH{1'b1}}};

  function automatic logic [DW-1:0] d_of_sel(input logic [2:0] s);
    logic [DW-1:0] d;
    d = 4'd7;
    case (s)
      3'b000: d = 4'd7;
      3'b001: d = 4'd6;
      3'b010: d = 4'd5;
      3'b011: d = 4'd4;
      3'b100: d = 4'd3;
      3'b101: d = 4'd2;
      3'b110: d = 4'd9;
      3'b111: d = 4'd8;
    endcase
    return d;
  endfunction

  logic [1:0]       state_q, state_d;
  logic [DW-1:0]    d_q, d_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic             last_q, last_d;

  logic [SW-1:0]    sel_d_ext, cur_d_ext, first_val, nxt;

  always_comb begin
    state_d   = state_q;
    d_d       = d_q;
    data_d    = data_q;
    last_d    = last_q;
    sel_d_ext = {{(SW-DW){1'b0}}, d_of_sel(sel)};
    cur_d_ext = {{(SW-DW){1'b0}}, d_q};
`ifdef DIVMULT_SKIP_ZERO_EN
    first_val = sel_d_ext;
`else
    first_val = '0;
`endif
    nxt = {2'b00, data_q} + cur_d_ext;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          d_d     = d_of_sel(sel);
          data_d  = first_val[WIDTH-1:0];
          last_d  = (first_val + sel_d_ext) > MAXV;
          state_d = S_EMIT;
        end
      end
      S_EMIT: begin
        if (out_ready) begin
          if (last_q) begin
            last_d  = 1'b0;
            state_d = S_DONE;
          end else begin
            // out_last for the next beat is looked ahead one step.
            data_d = nxt[WIDTH-1:0];
            last_d = (nxt + cur_d_ext) > MAXV;
          end
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      d_q     <= '0;
      data_q  <= '0;
      last_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      d_q     <= d_d;
      data_q  <= data_d;
      last_q  <= last_d;
    end
  end

  assign out_valid = (state_q == S_EMIT);
  assign busy      = (state_q != S_IDLE);
  assign done      = (state_q == S_DONE);
  assign out_data  = data_q;
  assign out_last  = last_q;

endmodule
